// File: rtl/param_fifo_if.sv
// -----------------------------------------------------------------------------
// param_fifo_if
//   Handshake/status bundle for param_fifo.
//   master : producer/consumer side. Drives wr, rd, flush, clr_err and data_in,
//            and observes the read data, the occupancy and the status flags.
//   slave  : FIFO side.
//   DATA_W and DEPTH must match the parameters of the attached param_fifo.
// -----------------------------------------------------------------------------
interface param_fifo_if #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) ();
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              wr;
  logic              rd;
  logic              flush;
  logic              clr_err;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_out;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_almost_full;
  logic              fifo_almost_empty;
  logic              fifo_overflow;
  logic              fifo_underflow;

  modport master (
    output wr, rd, flush, clr_err, data_in,
    input  data_out, fifo_count, fifo_full, fifo_empty,
           fifo_almost_full, fifo_almost_empty, fifo_overflow, fifo_underflow
  );

  modport slave (
    input  wr, rd, flush, clr_err, data_in,
    output data_out, fifo_count, fifo_full, fifo_empty,
           fifo_almost_full, fifo_almost_empty, fifo_overflow, fifo_underflow
  );
endinterface

// File: rtl/param_fifo.sv
// -----------------------------------------------------------------------------
// param_fifo
//   Parametrised single-clock FIFO with programmable almost-full/almost-empty
//   levels, an occupancy count, a synchronous flush and sticky overflow and
//   underflow flags with an explicit clear.
//
//   Ports:
//     clk    : rising-edge clock
//     rst_n  : asynchronous active-low reset
//     bus    : param_fifo_if.slave
//              wr/rd      write/read requests
//              flush      synchronous empty (same-cycle wr/rd are ignored)
//              clr_err    synchronous clear of the sticky error flags
//              data_in    write data
//              data_out   registered read data (1-cycle latency, holds value)
//              fifo_count occupancy, 0..DEPTH
//              fifo_*     status flags, all derived from the registered count
// -----------------------------------------------------------------------------
module param_fifo #(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = 12,
  parameter int AE_LEVEL = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  param_fifo_if.slave   bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  count_nxt;
  logic [DATA_W-1:0] data_out_q;
  logic              overflow_q;
  logic              underflow_q;

  logic full;
  logic empty;
  logic wr_acc;
  logic rd_acc;
  logic overflow_evt;
  logic underflow_evt;

  // Full/empty come from the count, never from pointer equality, so the
  // pointers can simply wrap at DEPTH.
  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

  // A write into a full FIFO is still accepted when a read frees a slot on
  // the same edge. Flush overrides both requests.
  assign wr_acc = bus.wr & (~full | bus.rd) & ~bus.flush;
  assign rd_acc = bus.rd & ~empty & ~bus.flush;

  assign overflow_evt  = bus.wr & full & ~bus.rd & ~bus.flush;
  assign underflow_evt = bus.rd & empty & ~bus.flush;

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    count_nxt = count;
    unique case ({wr_acc, rd_acc})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples its inputs as they were before the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      data_out_q <= '0;
    end else if (bus.flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) begin
        rd_ptr     <= rd_ptr + 1'b1;
        data_out_q <= mem[rd_ptr];
      end
      count <= count_nxt;
    end
  end

  // NOTE: the storage array has no reset; the count marks which entries are
  // valid, and leaving it unreset lets it map onto plain RAM.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr] <= bus.data_in;
  end

  // A new error on the same edge as clr_err takes priority over the clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (overflow_evt)     overflow_q <= 1'b1;
      else if (bus.clr_err) overflow_q <= 1'b0;

      if (underflow_evt)    underflow_q <= 1'b1;
      else if (bus.clr_err) underflow_q <= 1'b0;
    end
  end

  assign bus.data_out          = data_out_q;
  assign bus.fifo_count        = count;
  assign bus.fifo_full         = full;
  assign bus.fifo_empty        = empty;
  assign bus.fifo_almost_full  = (count >= CNT_W'(AF_LEVEL));
  assign bus.fifo_almost_empty = (count <= CNT_W'(AE_LEVEL));
  assign bus.fifo_overflow     = overflow_q;
  assign bus.fifo_underflow    = underflow_q;

endmodule

// File: doc/param_fifo.md
Name: param_fifo

Overview:
Parametrised synchronous single-clock FIFO. It is the successor to the fixed 8-bit × 16 fifo_memory. Adds:
- configurable width and depth
- programmable almost-full and almost-empty levels
- an occupancy count output
- a synchronous flush
- sticky overflow/underflow error flags with explicit clear
- defined simultaneous read/write at full and at empty

It sits between producer and consumer datapaths in the same clock domain.

Parameters:
- DATA_W, 8: data word width in bits.
- DEPTH, 16: number of entries; power of 2, ≥ 4.
- AF_LEVEL, 12: fifo_almost_full asserts when count ≥ AF_LEVEL; range 1..DEPTH.
- AE_LEVEL, 2: fifo_almost_empty asserts when count ≤ AE_LEVEL; range 0..DEPTH-1.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- wr  input  1  write request; data_in is captured on the rising edge when accepted.
- rd  input  1  read request.
- flush  input  1  synchronous flush, empties the FIFO.
- clr_err  input  1  synchronous clear of the sticky error flags.
- data_in  input  DATA_W  write data.
- data_out  output  DATA_W  registered read data.
- fifo_count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- fifo_full  output  1  count == DEPTH.
- fifo_empty  output  1  count == 0.
- fifo_almost_full  output  1  count ≥ AF_LEVEL.
- fifo_almost_empty  output  1  count ≤ AE_LEVEL.
- fifo_overflow  output  1  sticky: a write was attempted while full and no read occurred.
- fifo_underflow  output  1  sticky: a read was attempted while empty.

Behaviour:
- Reset (async, rst_n=0):
  - Pointers = 0, count = 0, data_out = 0.
  - fifo_empty = 1, fifo_almost_empty = 1.
  - fifo_full = 0, fifo_almost_full = 0 (AF_LEVEL ≥ 1).
  - fifo_overflow = 0, fifo_underflow = 0.
  - Memory contents are not reset.
- Flag timing: all flags and fifo_count are registered or derived from the registered count. They reflect the state after the current edge and are valid from the next cycle.
- Write accepted = wr & (!full | rd). Word is stored at wr_ptr, wr_ptr increments modulo DEPTH.
- Read accepted = rd & !empty. Word at rd_ptr is loaded into data_out on that edge (1-cycle latency), rd_ptr increments modulo DEPTH.
- data_out holds its last value when no read is accepted.
- Count update: +1 on write-only, −1 on read-only, unchanged when both are accepted or neither.
- Full with wr & rd: both accepted; the oldest word is output, the new word is stored, count stays DEPTH; no overflow.
- Empty with wr & rd: write accepted, read rejected, count becomes 1, fifo_underflow set. data_out is unchanged (no write-through).
- Overflow: wr & full & !rd sets fifo_overflow; data is dropped; pointers and count are unchanged.
- Underflow: rd & empty sets fifo_underflow; pointers are unchanged.
- Sticky flags hold until clr_err=1 or reset.
- If clr_err and a new error occur on the same edge, the new error wins (flag = 1).
- flush=1 on an edge:
  - Pointers and count go to 0; wr and rd in the same cycle are ignored.
  - data_out and the error flags are unaffected.
- Pointer wrap: log2(DEPTH)-bit pointers wrap naturally. Full/empty are decided by count, never by pointer equality.
- Reset asserted mid-operation clears state immediately (asynchronously); the first operation after deassertion behaves as on an empty FIFO.

Test Plan (DEPTH=16, DATA_W=8, AF_LEVEL=12, AE_LEVEL=2):
1. Reset, then rd=1 for one cycle → fifo_empty=1, fifo_underflow=1, data_out=0; then clr_err=1 → fifo_underflow=0.
2. Write 1..16 → fifo_full=1, fifo_count=16, fifo_almost_full=1 (it first rises after the 12th write). A 17th write of 99 → fifo_overflow=1, count stays 16. Read 16 words → data_out sequence is 1..16, then fifo_empty=1.
3. With the FIFO full of 1..16, wr=1, rd=1, data_in=50 → data_out=1, count stays 16, no overflow. Drain → 2..16 then 50.
4. With the FIFO empty, wr=1, rd=1, data_in=7 → count=1, fifo_underflow=1, data_out unchanged. Next read → data_out=7.
5. Write 8 words, flush=1 with wr=1 → count=0, fifo_empty=1, written word discarded. Write 5, read → data_out=5. Exercise pointer wrap with 40 write/read pairs → data matches in order.
6. Write 3 words, assert rst_n=0 asynchronously between edges → count=0, fifo_empty=1, data_out=0 immediately, without waiting for a clock edge.
